// File: rtl/seg7_scan_if.sv
// CPU-side handshake bundle for the 7-segment scanner: a value/dp pair offered
// with load, accepted while ready is high.
interface seg7_scan_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        ready;

    modport master (
        output value,
        output dp,
        output load,
        input  ready
    );

    modport slave (
        input  value,
        input  dp,
        input  load,
        output ready
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit common-anode hex display driver. A new value is held as
// pending and only swapped into the displayed copy at a frame boundary.
module seg7_scan #(
    parameter int SCAN_BITS = 7,
    parameter int LZB       = 0
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  host,
    input  logic        blank,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n
);

    typedef enum logic {
        IDLE,
        PENDING
    } hsState_t;

    hsState_t             state_q, state_d;
    logic [SCAN_BITS-1:0] count_q, count_d;
    logic [1:0]           digit_q, digit_d;
    logic [15:0]          activeValue_q, activeValue_d;
    logic [3:0]           activeDp_q, activeDp_d;
    logic [15:0]          pendingValue_q, pendingValue_d;
    logic [3:0]           pendingDp_q, pendingDp_d;
    logic [6:0]           segN_q, segN_d;
    logic                 dpN_q, dpN_d;
    logic [3:0]           anN_q, anN_d;

    logic                 tick;
    logic                 frameEnd;
    logic [3:0]           nibble;
    logic                 upperZero;

    function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign tick     = &count_q;
    assign frameEnd = tick && (digit_q == 2'd3);

    always_comb begin
        count_d = count_q + 1'b1;
        digit_d = tick ? digit_q + 2'd1 : digit_q;
    end

    // A load captured on the boundary cycle lands in PENDING only after that
    // edge, so the commit naturally waits a whole frame.
    always_comb begin
        state_d        = state_q;
        activeValue_d  = activeValue_q;
        activeDp_d     = activeDp_q;
        pendingValue_d = pendingValue_q;
        pendingDp_d    = pendingDp_q;
        host.ready     = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (host.load) begin
                    pendingValue_d = host.value;
                    pendingDp_d    = host.dp;
                    state_d        = PENDING;
                end
            end
            PENDING: begin
                if (frameEnd) begin
                    activeValue_d = pendingValue_q;
                    activeDp_d    = pendingDp_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nibble    = activeValue_q[{digit_q, 2'b00} +: 4];
        upperZero = 1'b0;
        case (digit_q)
            2'd1:    upperZero = (activeValue_q[15:4] == 12'h000);
            2'd2:    upperZero = (activeValue_q[15:8] == 8'h00);
            2'd3:    upperZero = (activeValue_q[15:12] == 4'h0);
            default: upperZero = 1'b0;
        endcase
    end

    // The count==0 cycle of every slot is forced dark so the previous digit's
    // segments never bleed onto the next anode.
    always_comb begin
        segN_d = hexGlyph(nibble);
        if ((LZB != 0) && upperZero) begin
            segN_d = 7'h7F;
        end
        dpN_d = ~activeDp_q[digit_q];
        anN_d = 4'hF;
        if (!blank && (count_q != '0)) begin
            anN_d = ~(4'b0001 << digit_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            digit_q        <= 2'd0;
            activeValue_q  <= 16'h0000;
            activeDp_q     <= 4'h0;
            pendingValue_q <= 16'h0000;
            pendingDp_q    <= 4'h0;
            segN_q         <= 7'h7F;
            dpN_q          <= 1'b1;
            anN_q          <= 4'hF;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            digit_q        <= digit_d;
            activeValue_q  <= activeValue_d;
            activeDp_q     <= activeDp_d;
            pendingValue_q <= pendingValue_d;
            pendingDp_q    <= pendingDp_d;
            segN_q         <= segN_d;
            dpN_q          <= dpN_d;
            anN_q          <= anN_d;
        end
    end

    assign seg_n = segN_q;
    assign dp_n  = dpN_q;
    assign an_n  = anN_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_BITS=3 (8 clocks/digit, 32/frame);
// one instance without and one with leading-zero blanking.
module tb_seg7_scan;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [3:0] an0, an1;

    int edges = 0;
    int vecs = 0;
    int miscompares = 0;

    logic [6:0] expZero [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
    logic [6:0] exp1A2F [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};
    logic [6:0] exp1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] lzbZero [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] lzb0050 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [6:0] lzb1000 [4] = '{7'h40, 7'h40, 7'h40, 7'h79};

    seg7_scan_if if0 ();
    seg7_scan_if if1 ();

    seg7_scan #(.SCAN_BITS(3), .LZB(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .host  (if0.slave),
        .blank (blank),
        .seg_n (seg0),
        .dp_n  (dp0),
        .an_n  (an0)
    );

    seg7_scan #(.SCAN_BITS(3), .LZB(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .host  (if1.slave),
        .blank (blank),
        .seg_n (seg1),
        .dp_n  (dp1),
        .an_n  (an1)
    );

    always #5 clk = ~clk;

    // Edges since reset release; output sampled after edge n shows scan position n-1.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [3:0] expAn(input int p);
        logic [3:0] one;
        one = 4'b0001;
        if ((p % 8) == 0) return 4'hF;
        return ~(one << 2'((p / 8) % 4));
    endfunction

    task automatic waitEdges(input int target);
        while (edges < target) @(negedge clk);
    endtask

    task automatic test_reset;
        if0.value = 16'h0000; if0.dp = 4'h0; if0.load = 1'b0;
        if1.value = 16'h0000; if1.dp = 4'h0; if1.load = 1'b0;
        #2 reset = 1'b1;
        #1;
        vecs++; if (an0 !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_an got %h want F", an0); end
        vecs++; if (seg0 !== 7'h7F) begin miscompares++; $display("[TB] FAIL reset_seg got %h want 7f", seg0); end
        vecs++; if (dp0 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dp got %b want 1", dp0); end
        repeat (3) @(negedge clk);
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", if0.ready); end
        vecs++; if (an1 !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_an_lzb got %h want F", an1); end
        reset = 1'b0;
    endtask

    task automatic test_idle_scan;
        for (int p = 0; p < 32; p++) begin
            int d;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            vecs++; if (an0 !== expAn(p)) begin miscompares++; $display("[TB] FAIL idle_an p=%0d got %h want %h", p, an0, expAn(p)); end
            vecs++; if (seg0 !== expZero[d]) begin miscompares++; $display("[TB] FAIL idle_seg p=%0d got %h want %h", p, seg0, expZero[d]); end
            vecs++; if (dp0 !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_dp p=%0d got %b want 1", p, dp0); end
        end
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_ready got %b want 1", if0.ready); end
    endtask

    task automatic test_load;
        waitEdges(40);
        if0.value = 16'h1A2F; if0.dp = 4'b0100; if0.load = 1'b1;
        waitEdges(41);
        if0.load = 1'b0;
        vecs++; if (if0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL load_ready_drop got %b want 0", if0.ready); end
    endtask

    task automatic test_ignored_load;
        waitEdges(50);
        if0.value = 16'hFFFF; if0.dp = 4'hF; if0.load = 1'b1;
        waitEdges(51);
        if0.load = 1'b0;
        vecs++; if (if0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_ready got %b want 0", if0.ready); end
        waitEdges(63);
        vecs++; if (if0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL boundary_ready got %b want 0", if0.ready); end
        waitEdges(64);
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_ready got %b want 1", if0.ready); end
        for (int p = 64; p < 96; p++) begin
            int d;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            vecs++; if (an0 !== expAn(p)) begin miscompares++; $display("[TB] FAIL show1A2F_an p=%0d got %h want %h", p, an0, expAn(p)); end
            vecs++; if (seg0 !== exp1A2F[d]) begin miscompares++; $display("[TB] FAIL show1A2F_seg p=%0d got %h want %h", p, seg0, exp1A2F[d]); end
            vecs++; if (dp0 !== (d != 2)) begin miscompares++; $display("[TB] FAIL show1A2F_dp p=%0d got %b want %b", p, dp0, (d != 2)); end
        end
    endtask

    task automatic test_boundary_load;
        waitEdges(127);
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_ready_pre got %b want 1", if0.ready); end
        if0.value = 16'h1234; if0.dp = 4'b0001; if0.load = 1'b1;
        waitEdges(128);
        if0.load = 1'b0;
        vecs++; if (if0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_ready_post got %b want 0", if0.ready); end
        for (int p = 128; p < 192; p++) begin
            int d;
            logic [6:0] want;
            logic wantDp;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            want   = (p < 160) ? exp1A2F[d] : exp1234[d];
            wantDp = (p < 160) ? (d != 2) : (d != 0);
            vecs++; if (seg0 !== want) begin miscompares++; $display("[TB] FAIL edge_seg p=%0d got %h want %h", p, seg0, want); end
            vecs++; if (dp0 !== wantDp) begin miscompares++; $display("[TB] FAIL edge_dp p=%0d got %b want %b", p, dp0, wantDp); end
        end
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_ready_end got %b want 1", if0.ready); end
    endtask

    task automatic test_lzb;
        waitEdges(192);
        vecs++; if (if1.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lzb_ready got %b want 1", if1.ready); end
        if1.value = 16'h0050; if1.dp = 4'h0; if1.load = 1'b1;
        waitEdges(193);
        if1.load = 1'b0;
        for (int p = 192; p < 256; p++) begin
            int d;
            logic [6:0] want;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            want = (p < 224) ? lzbZero[d] : lzb0050[d];
            vecs++; if (seg1 !== want) begin miscompares++; $display("[TB] FAIL lzb_seg p=%0d got %h want %h", p, seg1, want); end
            vecs++; if (dp1 !== 1'b1) begin miscompares++; $display("[TB] FAIL lzb_dp p=%0d got %b want 1", p, dp1); end
        end
        waitEdges(256);
        if1.value = 16'h1000; if1.load = 1'b1;
        waitEdges(257);
        if1.load = 1'b0;
        for (int p = 288; p < 320; p++) begin
            int d;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            vecs++; if (seg1 !== lzb1000[d]) begin miscompares++; $display("[TB] FAIL lzb1000_seg p=%0d got %h want %h", p, seg1, lzb1000[d]); end
        end
    endtask

    task automatic test_blank_reset;
        waitEdges(320);
        blank = 1'b1;
        if0.value = 16'hBEEF; if0.dp = 4'h0; if0.load = 1'b1;
        waitEdges(321);
        if0.load = 1'b0;
        vecs++; if (if0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL blank_ready got %b want 0", if0.ready); end
        for (int n = 321; n <= 340; n++) begin
            waitEdges(n);
            vecs++; if (an0 !== 4'hF) begin miscompares++; $display("[TB] FAIL blank_an n=%0d got %h want F", n, an0); end
        end
        blank = 1'b0;
        waitEdges(341);
        vecs++; if (an0 !== expAn(340)) begin miscompares++; $display("[TB] FAIL unblank_an got %h want %h", an0, expAn(340)); end
        waitEdges(344);
        vecs++; if (an0 !== expAn(343)) begin miscompares++; $display("[TB] FAIL prereset_an got %h want %h", an0, expAn(343)); end
        vecs++; if (seg0 !== 7'h24) begin miscompares++; $display("[TB] FAIL prereset_seg got %h want 24", seg0); end
        #2 reset = 1'b1;
        #1;
        vecs++; if (an0 !== 4'hF) begin miscompares++; $display("[TB] FAIL async_an got %h want F", an0); end
        vecs++; if (seg0 !== 7'h7F) begin miscompares++; $display("[TB] FAIL async_seg got %h want 7f", seg0); end
        vecs++; if (dp0 !== 1'b1) begin miscompares++; $display("[TB] FAIL async_dp got %b want 1", dp0); end
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL async_ready got %b want 1", if0.ready); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 40; p++) begin
            int d;
            waitEdges(p + 1);
            d = (p / 8) % 4;
            vecs++; if (an0 !== expAn(p)) begin miscompares++; $display("[TB] FAIL restart_an p=%0d got %h want %h", p, an0, expAn(p)); end
            vecs++; if (seg0 !== expZero[d]) begin miscompares++; $display("[TB] FAIL restart_seg p=%0d got %h want %h", p, seg0, expZero[d]); end
        end
        vecs++; if (if0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_ready got %b want 1", if0.ready); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load();
        test_ignored_load();
        test_boundary_load();
        test_lzb();
        test_blank_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
